// File: rtl/ppg_sweep_ctrl_if.sv
// ppg_sweep_ctrl_if: bundles the job-side and Iterate-side signals of the sweep controller.
//   master : the sweep controller (drives job status, it_start and the it_*_in operands)
//   slave  : its environment (job requester plus the Iterate datapath)
// Job side     : job_start, max_sweeps, xhat_init, r_init -> job_busy, job_done, converged,
//                timeout_err, sweep_count, xhat_result
// Iterate side : it_start, it_xhat_in, it_r_in, it_max_xj_in -> it_done, it_xhat_out,
//                it_r_out, it_max_xj_out, it_max_dxj_out
interface ppg_sweep_ctrl_if #(
  parameter int unsigned I  = 10,
  parameter int unsigned J  = 2,
  parameter int unsigned N  = 8,
  parameter int unsigned SW = 8
);
  // Job side
  logic          job_start;
  logic [SW-1:0] max_sweeps;
  logic [N-1:0]  xhat_init [J];
  logic [N-1:0]  r_init [I];
  logic          job_busy;
  logic          job_done;
  logic          converged;
  logic          timeout_err;
  logic [SW-1:0] sweep_count;
  logic [N-1:0]  xhat_result [J];

  // Iterate side
  logic          it_start;
  logic          it_done;
  logic [N-1:0]  it_xhat_in [J];
  logic [N-1:0]  it_r_in [I];
  logic [N-1:0]  it_max_xj_in;
  logic [N-1:0]  it_xhat_out [J];
  logic [N-1:0]  it_r_out [I];
  logic [N-1:0]  it_max_xj_out;
  logic [N-1:0]  it_max_dxj_out;

  modport master (
    input  job_start, max_sweeps, xhat_init, r_init,
    input  it_done, it_xhat_out, it_r_out, it_max_xj_out, it_max_dxj_out,
    output job_busy, job_done, converged, timeout_err, sweep_count, xhat_result,
    output it_start, it_xhat_in, it_r_in, it_max_xj_in
  );

  modport slave (
    output job_start, max_sweeps, xhat_init, r_init,
    output it_done, it_xhat_out, it_r_out, it_max_xj_out, it_max_dxj_out,
    input  job_busy, job_done, converged, timeout_err, sweep_count, xhat_result,
    input  it_start, it_xhat_in, it_r_in, it_max_xj_in
  );
endinterface

// File: rtl/ppg_sweep_ctrl.sv
// ppg_sweep_ctrl: outer-loop sequencer for the Iterate datapath. One job is one
// proximal-gradient solve: load xhat/r, repeatedly launch Iterate feeding each sweep's
// results back in, and stop on convergence, sweep limit, or a hung Iterate.
// Ports:
//   clk  - clock, all state updates on the rising edge
//   rst  - synchronous active-high reset (returns to IDLE, clears all state and outputs)
//   bus  - ppg_sweep_ctrl_if master modport (job handshake/results and Iterate operands)
module ppg_sweep_ctrl #(
  parameter int unsigned I         = 10,
  parameter int unsigned J         = 2,
  parameter int unsigned N         = 8,
  parameter int unsigned SW        = 8,
  parameter int unsigned TOL_SHIFT = 4,
  parameter int unsigned TIMEOUT   = 1023
) (
  input  logic            clk,
  input  logic            rst,
  ppg_sweep_ctrl_if.master bus
);

  localparam int unsigned WW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  typedef enum logic [2:0] {
    StIdle,
    StLaunch,
    StWait,
    StCheck,
    StDone
  } state_e;

  state_e        state_q, state_d;
  logic [N-1:0]  xhat_q [J];
  logic [N-1:0]  xhat_d [J];
  logic [N-1:0]  r_q [I];
  logic [N-1:0]  r_d [I];
  logic [N-1:0]  mxj_q, mxj_d;
  logic [N-1:0]  dxj_q, dxj_d;
  logic [SW-1:0] sweep_q, sweep_d;
  logic [SW-1:0] limit_q, limit_d;
  logic          conv_q, conv_d;
  logic          tout_q, tout_d;
  logic [WW-1:0] wait_q, wait_d;

  always_comb begin
    state_d = state_q;
    xhat_d  = xhat_q;
    r_d     = r_q;
    mxj_d   = mxj_q;
    dxj_d   = dxj_q;
    sweep_d = sweep_q;
    limit_d = limit_q;
    conv_d  = conv_q;
    tout_d  = tout_q;
    wait_d  = wait_q;

    unique case (state_q)
      StIdle: begin
        if (bus.job_start) begin
          xhat_d  = bus.xhat_init;
          r_d     = bus.r_init;
          mxj_d   = '0;
          sweep_d = '0;
          conv_d  = 1'b0;
          tout_d  = 1'b0;
          // A zero limit still runs one sweep.
          limit_d = (bus.max_sweeps == '0) ? SW'(1) : bus.max_sweeps;
          state_d = StLaunch;
        end
      end

      StLaunch: begin
        wait_d  = '0;
        state_d = StWait;
      end

      StWait: begin
        if (bus.it_done) begin
          xhat_d  = bus.it_xhat_out;
          r_d     = bus.it_r_out;
          mxj_d   = bus.it_max_xj_out;
          dxj_d   = bus.it_max_dxj_out;
          if (sweep_q != '1) begin
            sweep_d = sweep_q + SW'(1);
          end
          state_d = StCheck;
        end else if (wait_q == WW'(TIMEOUT)) begin
          tout_d  = 1'b1;
          state_d = StDone;
        end else begin
          wait_d = wait_q + WW'(1);
        end
      end

      StCheck: begin
        // Magnitudes are unsigned; the tolerance is a fraction of the largest |xj|.
        if (dxj_q <= (mxj_q >> TOL_SHIFT)) begin
          conv_d  = 1'b1;
          state_d = StDone;
        end else if (sweep_q >= limit_q) begin
          state_d = StDone;
        end else begin
          state_d = StLaunch;
        end
      end

      StDone: begin
        state_d = StIdle;
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      xhat_q  <= '{default: '0};
      r_q     <= '{default: '0};
      mxj_q   <= '0;
      dxj_q   <= '0;
      sweep_q <= '0;
      limit_q <= '0;
      conv_q  <= 1'b0;
      tout_q  <= 1'b0;
      wait_q  <= '0;
    end else begin
      state_q <= state_d;
      xhat_q  <= xhat_d;
      r_q     <= r_d;
      mxj_q   <= mxj_d;
      dxj_q   <= dxj_d;
      sweep_q <= sweep_d;
      limit_q <= limit_d;
      conv_q  <= conv_d;
      tout_q  <= tout_d;
      wait_q  <= wait_d;
    end
  end

  // Moore outputs; operand registers drive Iterate directly and hold through LAUNCH/WAIT.
  assign bus.job_busy     = (state_q != StIdle);
  assign bus.job_done     = (state_q == StDone);
  assign bus.it_start     = (state_q == StLaunch);
  assign bus.converged    = conv_q;
  assign bus.timeout_err  = tout_q;
  assign bus.sweep_count  = sweep_q;
  assign bus.xhat_result  = xhat_q;
  assign bus.it_xhat_in   = xhat_q;
  assign bus.it_r_in      = r_q;
  assign bus.it_max_xj_in = mxj_q;

endmodule

// File: tb/tb_ppg_sweep_ctrl.sv
// Bench for ppg_sweep_ctrl: a scripted Iterate stub, a table of jobs with expected results,
// a scoreboard for sweep operands and job results, plus ignored-start and mid-job reset cases.
module tb_ppg_sweep_ctrl;

  localparam int unsigned I         = 10;
  localparam int unsigned J         = 2;
  localparam int unsigned N         = 8;
  localparam int unsigned SW        = 8;
  localparam int unsigned TOL_SHIFT = 4;
  localparam int unsigned TIMEOUT   = 1023;

  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  ppg_sweep_ctrl_if #(.I(I), .J(J), .N(N), .SW(SW)) bus ();

  ppg_sweep_ctrl #(
    .I(I), .J(J), .N(N), .SW(SW), .TOL_SHIFT(TOL_SHIFT), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.master)
  );

  typedef struct packed {
    int         lat;
    logic [7:0] mxj;
    logic [7:0] dxj;
    logic [7:0] seed;
  } script_t;

  typedef struct packed {
    logic [J-1:0][7:0] xhat;
    logic [I-1:0][7:0] r;
    logic [7:0]        mxj;
  } in_t;

  typedef struct packed {
    logic              conv;
    logic              tout;
    logic [7:0]        cnt;
    logic [J-1:0][7:0] xhat;
  } res_t;

  // Per-sweep fields: element 0 is the rightmost byte.
  typedef struct packed {
    logic [7:0]      ms;
    int              nsw;
    logic [3:0][7:0] lat;
    logic [3:0][7:0] mxj;
    logic [3:0][7:0] dxj;
    logic            conv;
    logic            tout;
    logic [7:0]      cnt;
  } vec_t;

  script_t script_q[$];
  in_t     exp_in_q[$];
  res_t    res_q[$];
  vec_t    vecs[8];

  int tests = 0;
  int fails = 0;

  bit      pend = 1'b0;
  int      cnt_dn = 0;
  script_t cur;
  int      start_cnt = 0;
  int      first_start_cyc = 0;
  int      last_start_cyc = 0;
  int      last_done_cyc = 0;
  int      done_cnt = 0;
  int      done_cyc = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [7:0] seed_of(input int v, input int s);
    return 8'(v * 40 + s * 7 + 1);
  endfunction

  // Iterate stub: on it_start, compare operands with the scoreboard and arm the next script
  // entry; lat cycles later pulse it_done with outputs derived from the entry's seed.
  always @(negedge clk) begin : stub
    in_t e;
    in_t n;
    bus.it_done = 1'b0;
    if (bus.it_start) begin
      start_cnt++;
      if (start_cnt == 1) first_start_cyc = cyc;
      else check("sweep_gap", 64'(cyc - last_done_cyc), 64'd2);
      last_start_cyc = cyc;
      if (exp_in_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL it_start_unexpected: got it_start, expected none (cycle %0d)", cyc);
      end else begin
        e = exp_in_q.pop_front();
        for (int j = 0; j < J; j++) check("it_xhat_in", 64'(bus.it_xhat_in[j]), 64'(e.xhat[j]));
        for (int i = 0; i < I; i++) check("it_r_in", 64'(bus.it_r_in[i]), 64'(e.r[i]));
        check("it_max_xj_in", 64'(bus.it_max_xj_in), 64'(e.mxj));
      end
      if (script_q.size() > 0) begin
        cur    = script_q.pop_front();
        cnt_dn = cur.lat;
        pend   = 1'b1;
      end
    end else if (pend) begin
      cnt_dn--;
      if (cnt_dn == 0) begin
        bus.it_done = 1'b1;
        for (int j = 0; j < J; j++) begin
          bus.it_xhat_out[j] = cur.seed + 8'(j);
          n.xhat[j]          = cur.seed + 8'(j);
        end
        for (int i = 0; i < I; i++) begin
          bus.it_r_out[i] = (cur.seed ^ 8'h5A) + 8'(i);
          n.r[i]          = (cur.seed ^ 8'h5A) + 8'(i);
        end
        bus.it_max_xj_out  = cur.mxj;
        bus.it_max_dxj_out = cur.dxj;
        n.mxj              = cur.mxj;
        exp_in_q.push_back(n);
        pend          = 1'b0;
        last_done_cyc = cyc;
      end
    end
  end

  // Job-result monitor.
  always @(negedge clk) begin : mon
    res_t e;
    if (bus.job_done) begin
      done_cnt++;
      done_cyc = cyc;
      check("busy_in_done", 64'(bus.job_busy), 64'd1);
      if (res_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL job_done_unexpected: got job_done, expected none (cycle %0d)", cyc);
      end else begin
        e = res_q.pop_front();
        check("converged", 64'(bus.converged), 64'(e.conv));
        check("timeout_err", 64'(bus.timeout_err), 64'(e.tout));
        check("sweep_count", 64'(bus.sweep_count), 64'(e.cnt));
        for (int j = 0; j < J; j++) check("xhat_result", 64'(bus.xhat_result[j]), 64'(e.xhat[j]));
      end
    end
  end

  task automatic set_inputs(input int vi, output in_t e);
    for (int j = 0; j < J; j++) begin
      bus.xhat_init[j] = 8'(vi * 3 + j + 17);
      e.xhat[j]        = 8'(vi * 3 + j + 17);
    end
    for (int i = 0; i < I; i++) begin
      bus.r_init[i] = 8'(vi * 5 + i + 96);
      e.r[i]        = 8'(vi * 5 + i + 96);
    end
    e.mxj = 8'h00;
  endtask

  task automatic run_job(input vec_t v, input int vi, input bit poke);
    in_t  e;
    res_t r;
    int   d0;
    int   c0;
    script_q.delete();
    exp_in_q.delete();
    start_cnt = 0;
    bus.max_sweeps = v.ms;
    set_inputs(vi, e);
    exp_in_q.push_back(e);
    for (int s = 0; s < v.nsw; s++) begin
      script_q.push_back('{lat: int'(v.lat[s]), mxj: v.mxj[s], dxj: v.dxj[s],
                           seed: seed_of(vi, s)});
    end
    r.conv = v.conv;
    r.tout = v.tout;
    r.cnt  = v.cnt;
    for (int j = 0; j < J; j++) begin
      r.xhat[j] = (v.cnt == 0) ? e.xhat[j] : seed_of(vi, int'(v.cnt) - 1) + 8'(j);
    end
    res_q.push_back(r);
    d0 = done_cnt;
    bus.job_start = 1'b1;
    c0 = cyc;
    @(negedge clk);
    bus.job_start = 1'b0;
    for (int k = 0; k < 5000 && done_cnt == d0; k++) begin
      @(negedge clk);
      if (poke && k == 1) begin
        // Start request mid-WAIT with a different limit and estimate; must be dropped.
        bus.job_start    = 1'b1;
        bus.max_sweeps   = 8'd1;
        bus.xhat_init[0] = 8'hAA;
      end else begin
        bus.job_start = 1'b0;
      end
    end
    @(negedge clk);
    check("job_done_count", 64'(done_cnt - d0), 64'd1);
    check("first_start_lat", 64'(first_start_cyc - c0), 64'd1);
    check("start_count", 64'(start_cnt), 64'((v.nsw == 0) ? 1 : v.nsw));
    if (v.tout) check("timeout_lat", 64'(done_cyc - last_start_cyc), 64'(TIMEOUT + 2));
    else        check("done_lat", 64'(done_cyc - last_done_cyc), 64'd2);
    check("busy_after_done", 64'(bus.job_busy), 64'd0);
    check("done_pulse_width", 64'(bus.job_done), 64'd0);
    check("converged_held", 64'(bus.converged), 64'(v.conv));
    check("count_held", 64'(bus.sweep_count), 64'(v.cnt));
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: got no finish, expected finish within time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    in_t e;
    rst           = 1'b1;
    bus.job_start = 1'b0;
    bus.max_sweeps = '0;
    for (int j = 0; j < J; j++) bus.xhat_init[j] = '0;
    for (int i = 0; i < I; i++) bus.r_init[i] = '0;

    vecs[0] = '{ms: 8'd5, nsw: 1, lat: {8'd0, 8'd0, 8'd0, 8'd20},
                mxj: {8'h00, 8'h00, 8'h00, 8'h40}, dxj: {8'h00, 8'h00, 8'h00, 8'h04},
                conv: 1'b1, tout: 1'b0, cnt: 8'd1};
    vecs[1] = '{ms: 8'd8, nsw: 3, lat: {8'd0, 8'd3, 8'd7, 8'd5},
                mxj: {8'h00, 8'h30, 8'h30, 8'h30}, dxj: {8'h00, 8'h02, 8'h08, 8'h10},
                conv: 1'b1, tout: 1'b0, cnt: 8'd3};
    vecs[2] = '{ms: 8'd4, nsw: 4, lat: {8'd4, 8'd2, 8'd9, 8'd6},
                mxj: {8'h30, 8'h30, 8'h30, 8'h30}, dxj: {8'h7F, 8'h7F, 8'h7F, 8'h7F},
                conv: 1'b0, tout: 1'b0, cnt: 8'd4};
    vecs[3] = '{ms: 8'd0, nsw: 1, lat: {8'd0, 8'd0, 8'd0, 8'd1},
                mxj: {8'h00, 8'h00, 8'h00, 8'h30}, dxj: {8'h00, 8'h00, 8'h00, 8'h7F},
                conv: 1'b0, tout: 1'b0, cnt: 8'd1};
    vecs[4] = '{ms: 8'd3, nsw: 1, lat: {8'd0, 8'd0, 8'd0, 8'd2},
                mxj: {8'h00, 8'h00, 8'h00, 8'h00}, dxj: {8'h00, 8'h00, 8'h00, 8'h00},
                conv: 1'b1, tout: 1'b0, cnt: 8'd1};
    vecs[5] = '{ms: 8'd1, nsw: 1, lat: {8'd0, 8'd0, 8'd0, 8'd3},
                mxj: {8'h00, 8'h00, 8'h00, 8'h40}, dxj: {8'h00, 8'h00, 8'h00, 8'h05},
                conv: 1'b0, tout: 1'b0, cnt: 8'd1};
    vecs[6] = '{ms: 8'd2, nsw: 1, lat: {8'd0, 8'd0, 8'd0, 8'd4},
                mxj: {8'h00, 8'h00, 8'h00, 8'hF0}, dxj: {8'h00, 8'h00, 8'h00, 8'h0F},
                conv: 1'b1, tout: 1'b0, cnt: 8'd1};
    vecs[7] = '{ms: 8'd3, nsw: 0, lat: '0, mxj: '0, dxj: '0,
                conv: 1'b0, tout: 1'b1, cnt: 8'd0};

    repeat (3) @(negedge clk);
    check("rst_busy", 64'(bus.job_busy), 64'd0);
    check("rst_done", 64'(bus.job_done), 64'd0);
    check("rst_it_start", 64'(bus.it_start), 64'd0);
    check("rst_sweep_count", 64'(bus.sweep_count), 64'd0);
    check("rst_xhat_result", 64'(bus.xhat_result[1]), 64'd0);
    rst = 1'b0;
    @(negedge clk);

    for (int v = 0; v < 8; v++) run_job(vecs[v], v, 1'b0);

    // Start request during WAIT is ignored: same outcome as the plain feedback job.
    run_job(vecs[1], 1, 1'b1);

    // Reset mid-job, then a late it_done that must be ignored.
    script_q.delete();
    exp_in_q.delete();
    start_cnt = 0;
    bus.max_sweeps = 8'd5;
    set_inputs(9, e);
    exp_in_q.push_back(e);
    script_q.push_back('{lat: 30, mxj: 8'h40, dxj: 8'h01, seed: seed_of(9, 0)});
    bus.job_start = 1'b1;
    @(negedge clk);
    bus.job_start = 1'b0;
    repeat (8) @(negedge clk);
    check("busy_mid_job", 64'(bus.job_busy), 64'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("midrst_busy", 64'(bus.job_busy), 64'd0);
    check("midrst_it_start", 64'(bus.it_start), 64'd0);
    check("midrst_xhat_result", 64'(bus.xhat_result[0]), 64'd0);
    check("midrst_it_r_in", 64'(bus.it_r_in[3]), 64'd0);
    check("midrst_sweep_count", 64'(bus.sweep_count), 64'd0);
    repeat (30) @(negedge clk);
    check("late_done_busy", 64'(bus.job_busy), 64'd0);
    check("late_done_count", 64'(bus.sweep_count), 64'd0);
    check("late_done_xhat", 64'(bus.xhat_result[0]), 64'd0);
    check("late_done_starts", 64'(start_cnt), 64'd1);

    run_job(vecs[0], 0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
